// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// ALU function codes for mfhi/mflo, and the control FSM states.
package hilo_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_DIVU  = 2'b01,
    MD_MULT  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  // ALU FunctC codes that route HI/LO onto the result bus.
  localparam logic [3:0] FUNCTC_MFHI = 4'b0101;
  localparam logic [3:0] FUNCTC_MFLO = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Iterative unsigned datapath: shift-add multiply / restoring divide, one bit per step.
// The step result is exposed combinationally so the caller can capture the final step on the same edge.
module hilo_iter_core #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_nxt_o,
  output logic [WIDTH-1:0] lo_nxt_o
);

  localparam int CW = $clog2(ITERS);

  logic [2*WIDTH-1:0] acc_q, acc_d, step_val;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum, rem_sh, trial;

  always_comb begin
    // Multiply: add into the upper half, then shift right with the carry entering the top.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: shift left one bit, then trial-subtract the divisor from the partial remainder.
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    trial   = rem_sh - {1'b0, opnd_q};
    if (is_div_q) begin
      if (trial[WIDTH]) begin
        step_val = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        step_val = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_val = {mul_sum, acc_q[WIDTH-1:1]};
    end

    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      acc_d    = {{WIDTH{1'b0}}, a_i};
      opnd_d   = b_i;
      is_div_d = is_div_i;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d = step_val;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last_o   = (cnt_q == CW'(ITERS - 1));
  assign hi_nxt_o = step_val[2*WIDTH-1:WIDTH];
  assign lo_nxt_o = step_val[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner with a 32-cycle multiply/divide engine; result lands 32 edges after accept, busy stalls issue.
// Define HILO_SIGNED_EN to build signed MULT/DIV (magnitude datapath plus sign fixup).
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             div_zero_q, div_zero_d;
  logic             is_div_q, is_div_d;
  logic             b_zero_q, b_zero_d;
  logic             accept, step, finish, core_last, op_div;
  logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo, res_hi, res_lo;

  assign op_div = md_is_div(md_op_e'(op));

`ifdef HILO_SIGNED_EN
  logic neg_a, neg_b, neg_a_q, neg_b_q;

  assign neg_a = op[1] & a[WIDTH-1];
  assign neg_b = op[1] & b[WIDTH-1];
  assign a_mag = neg_a ? (~a + 1'b1) : a;
  assign b_mag = neg_b ? (~b + 1'b1) : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (accept) begin
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  hilo_iter_core #(
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .step_i   (step),
    .is_div_i (op_div),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .last_o   (core_last),
    .hi_nxt_o (core_hi),
    .lo_nxt_o (core_lo)
  );

  always_comb begin
    res_hi = core_hi;
    res_lo = core_lo;
`ifdef HILO_SIGNED_EN
    if (!is_div_q) begin
      if (neg_a_q ^ neg_b_q) {res_hi, res_lo} = ~{core_hi, core_lo} + 1'b1;
    end else begin
      if (neg_a_q ^ neg_b_q) res_lo = ~core_lo + 1'b1;
      if (neg_a_q)           res_hi = ~core_hi + 1'b1;
      // Divide-by-zero reports LO as all-ones regardless of operand signs.
      if (b_zero_q)          res_lo = '1;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    busy       = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    accept     = start && !flush && (state_q != ST_RUN);
    step       = (state_q == ST_RUN) && !flush;
    finish     = step && core_last;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    is_div_d   = is_div_q;
    b_zero_d   = b_zero_q;

    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (flush)       state_d = ST_IDLE;
        else if (finish) state_d = ST_DONE;
      end
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      div_zero_d = 1'b0;
      is_div_d   = op_div;
      b_zero_d   = (b == '0);
    end
    // An op's result wins over any register write; writes only land while idle.
    if (finish) begin
      hi_d = res_hi;
      lo_d = res_lo;
      if (is_div_q && b_zero_q) div_zero_d = 1'b1;
    end else if (!busy) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      is_div_q   <= 1'b0;
      b_zero_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      is_div_q   <= is_div_d;
      b_zero_q   <= b_zero_d;
    end
  end

  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected HI/LO/div_zero queued at issue, checked on done.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  hilo_muldiv_unit #(.WIDTH(W), .ITERS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, q, r;
    logic [2*W-1:0] p;
    sx = longint'(x);
    sy = longint'(y);
`ifdef HILO_SIGNED_EN
    if (o[1]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end
`endif
    e.dz = 1'b0;
    if (!o[0]) begin
      p = 64'(sx * sy);
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else if (y == '0) begin
      e.hi = x;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      e.hi = r[W-1:0];
      e.lo = q[W-1:0];
    end
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_done hi=%h lo=%h with no op outstanding", hi, lo);
      end else begin
        e = exp_q.pop_front();
        if ({hi, lo, div_zero} !== e)
          $display("FAIL result got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                   hi, lo, div_zero, e.hi, e.lo, e.dz);
        else n_pass++;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b expected 0", done); else n_pass++;
    n_checks++; if (div_zero !== 1'b0) $display("FAIL reset_dz got %b expected 0", div_zero); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo got %h_%h expected 0", hi, lo); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu;
    int c;
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_checks++; if (busy !== 1'b1) $display("FAIL multu_busy got %b expected 1", busy); else n_pass++;
    wait_done(c);
    n_checks++; if (c != 32) $display("FAIL multu_latency got %0d expected 32", c); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL multu_busy_at_done got %b expected 0", busy); else n_pass++;
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_max got %h_%h expected fffffffe_00000001", hi, lo);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL done_pulse_width got %b expected 0", done); else n_pass++;
  endtask

  task automatic test_divu;
    int c;
    issue(2'b01, 32'd100, 32'd7);
    wait_done(c);
    n_checks++;
    if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu_100_7 got lo=%0d hi=%0d expected lo=14 hi=2", lo, hi);
    else n_pass++;
    issue(2'b01, 32'd5, 32'd0);
    wait_done(c);
    n_checks++;
    if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF || div_zero !== 1'b1)
      $display("FAIL divu_by_zero got hi=%h lo=%h dz=%b expected 5 ffffffff 1", hi, lo, div_zero);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (div_zero !== 1'b1) $display("FAIL dz_sticky got %b expected 1", div_zero); else n_pass++;
    issue(2'b00, 32'd6, 32'd7);
    n_checks++; if (div_zero !== 1'b0) $display("FAIL dz_clear_on_start got %b expected 0", div_zero); else n_pass++;
    wait_done(c);
    n_checks++; if (c != 32) $display("FAIL mul_after_dz timeout cycles=%0d expected 32", c); else n_pass++;
  endtask

  task automatic test_random_ops;
    int c;
    logic [W-1:0] x, y;
    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = $urandom >> $urandom_range(0, 28);
      if (i == 5) y = '0;
      issue(2'($urandom_range(0, 3)), x, y);
      wait_done(c);
      n_checks++; if (c != 32) $display("FAIL random_op_%0d latency got %0d expected 32", i, c); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_busy_flush;
    logic [W-1:0] h0, l0;
    int seen;
    h0 = hi; l0 = lo;
    op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op = 2'b01; a = 32'd99; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL busy_ignore_start got busy=%b expected 1", busy); else n_pass++;
    repeat (6) @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy got %b expected 0", busy); else n_pass++;
    n_checks++;
    if (hi !== h0 || lo !== l0) $display("FAIL flush_hilo got %h_%h expected %h_%h", hi, lo, h0, l0);
    else n_pass++;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_checks++; if (seen != 0) $display("FAIL flush_no_activity got %0d active cycles expected 0", seen); else n_pass++;
  endtask

  task automatic test_mthi_mtlo;
    int c;
    wdata = 32'h0000_1234; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    n_checks++; if (lo !== 32'h1234) $display("FAIL mtlo got %h expected 00001234", lo); else n_pass++;
    wdata = 32'hAAAA_5555; hi_we = 1'b1; lo_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    n_checks++;
    if (hi !== 32'hAAAA_5555 || lo !== 32'hAAAA_5555) $display("FAIL mthi_mtlo_both got %h_%h expected aaaa5555 both", hi, lo);
    else n_pass++;
    wdata = 32'h0000_CAFE; hi_we = 1'b1;
    issue(2'b00, 32'd2, 32'd3);
    hi_we = 1'b0;
    n_checks++; if (hi !== 32'hCAFE) $display("FAIL mthi_with_start got %h expected 0000cafe", hi); else n_pass++;
    wdata = 32'h0000_DEAD; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0;
    n_checks++; if (hi !== 32'hCAFE) $display("FAIL mthi_while_busy got %h expected 0000cafe", hi); else n_pass++;
    wait_done(c);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd6) $display("FAIL result_overwrites_mthi got %h_%h expected 0_6", hi, lo);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int c;
    issue(2'b01, 32'd1000, 32'd10);
    wait_done(c);
    n_checks++; if (c != 32) $display("FAIL b2b_first latency got %0d expected 32", c); else n_pass++;
    issue(2'b00, 32'h0001_0000, 32'h0001_0000);
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept_in_done got busy=%b expected 1", busy); else n_pass++;
    wait_done(c);
    n_checks++; if (c != 32) $display("FAIL b2b_second latency got %0d expected 32", c); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int c;
    wdata = 32'h0000_0055; lo_we = 1'b1; hi_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0; hi_we = 1'b0;
    issue(2'b01, 32'hFFFF_0000, 32'd3);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0)
      $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    else n_pass++;
    exp_q.delete();
    #1 rst = 1'b0;
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7);
    wait_done(c);
    n_checks++; if (c != 32) $display("FAIL start_after_reset latency got %0d expected 32", c); else n_pass++;
    @(negedge clk);
  endtask

`ifdef HILO_SIGNED_EN
  task automatic test_signed;
    int c;
    issue(2'b10, -32'sd3, 32'd5);
    wait_done(c);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) $display("FAIL mult_neg3_5 got %h_%h expected ffffffff_fffffff1", hi, lo);
    else n_pass++;
    issue(2'b11, -32'sd7, 32'd2);
    wait_done(c);
    n_checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) $display("FAIL div_neg7_2 got lo=%h hi=%h expected fffffffd ffffffff", lo, hi);
    else n_pass++;
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(c);
    n_checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) $display("FAIL div_overflow got lo=%h hi=%h expected 80000000 0", lo, hi);
    else n_pass++;
    issue(2'b11, -32'sd7, 32'd0);
    wait_done(c);
    n_checks++; if (c != 32) $display("FAIL signed_div_zero latency got %0d expected 32", c); else n_pass++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_random_ops();
    test_busy_flush();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid_op();
`ifdef HILO_SIGNED_EN
    test_signed();
`endif
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL outstanding_ops got %0d expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
